// File: rtl/bcu_pkg.sv
// Shared definitions for the multiplexed bus cycle unit: state encoding,
// transfer size encoding and beat planning helpers.
package bcu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_T1,
        ST_T2,
        ST_T3,
        ST_TW,
        ST_T4,
        ST_HOLD
    } bcu_state_e;

    localparam logic SIZE_BYTE = 1'b0;
    localparam logic SIZE_WORD = 1'b1;

    // A transfer never needs more than two beats, so a 2-bit count suffices.
    localparam int BEAT_W = 2;

    function automatic bit bus_bytes_legal(input int bus_bytes);
        return (bus_bytes == 1) || (bus_bytes == 2);
    endfunction

    // Byte-wide bus: one beat per byte. Two-lane bus: only a word that
    // straddles an even boundary needs a second beat.
    function automatic logic [BEAT_W-1:0] beat_count(input int   bus_bytes,
                                                     input logic size,
                                                     input logic addr_lsb);
        if (size == SIZE_BYTE) return BEAT_W'(1);
        if (bus_bytes == 1)    return BEAT_W'(2);
        return addr_lsb ? BEAT_W'(2) : BEAT_W'(1);
    endfunction

endpackage

// File: rtl/bcu_beat_ctr.sv
// Beat index counter for one transfer: cleared at transfer start, stepped
// after each non-final beat, and flags the final beat.
module bcu_beat_ctr
    import bcu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              inc,
    input  logic [BEAT_W-1:0] total,
    output logic [BEAT_W-1:0] idx,
    output logic              last_beat
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx <= '0;
        end else if (clr) begin
            idx <= '0;
        end else if (inc) begin
            idx <= idx + BEAT_W'(1);
        end
    end

    assign last_beat = ((idx + BEAT_W'(1)) == total);

endmodule

// File: rtl/bus_cycle_unit.sv
// Core-to-bus interface: runs T1-T4 multiplexed address/data cycles with
// ready wait states and hold/hlda arbitration on a 1- or 2-lane bus.
module bus_cycle_unit
    import bcu_pkg::*;
#(
    parameter int BUS_BYTES = 1,
    parameter int ADDR_W    = 20
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req,
    input  logic                   we,
    input  logic                   io,
    input  logic                   size,
    input  logic [ADDR_W-1:0]      addr,
    input  logic [15:0]            wdata,
    output logic [15:0]            rdata,
    output logic                   done,
    output logic                   busy,
    output logic [ADDR_W-1:0]      a,
    output logic [8*BUS_BYTES-1:0] ad_o,
    input  logic [8*BUS_BYTES-1:0] ad_i,
    output logic                   ad_oe,
    output logic                   ale,
    output logic                   rd_n,
    output logic                   wr_n,
    output logic                   den_n,
    output logic                   dtr,
    output logic                   iom,
    input  logic                   ready,
    input  logic                   hold,
    output logic                   hlda
);

    localparam int AD_W = 8 * BUS_BYTES;

    if (!bus_bytes_legal(BUS_BYTES)) begin : g_bad_bus_bytes
        $error("bus_cycle_unit: BUS_BYTES must be 1 or 2");
    end

    bcu_state_e        state_q, state_d;
    logic              start, advance, capture;

    logic              we_q, io_q, size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       wdata_q;
    logic [BEAT_W-1:0] beats_q;
    logic [15:0]       rdata_q;

    logic [BEAT_W-1:0] beat_idx;
    logic              last_beat;
    logic [ADDR_W-1:0] beat_addr;

    logic              full_word, lane_hi;
    logic [7:0]        wbyte, rbyte;
    logic [15:0]       wlanes, ad_i_ext;

    bcu_beat_ctr u_beat_ctr (
        .clk       (clk),
        .rst       (rst),
        .clr       (start),
        .inc       (advance),
        .total     (beats_q),
        .idx       (beat_idx),
        .last_beat (last_beat)
    );

    assign beat_addr = addr_q + ADDR_W'(beat_idx);

    // An aligned word on a two-lane bus moves both bytes in one beat; every
    // other beat moves the byte numbered by the beat index on one lane.
    assign full_word = (BUS_BYTES == 2) && (size_q == SIZE_WORD) && (beats_q == BEAT_W'(1));
    assign lane_hi   = (BUS_BYTES == 2) ? beat_addr[0] : 1'b0;
    assign wbyte     = beat_idx[0] ? wdata_q[15:8] : wdata_q[7:0];
    assign wlanes    = full_word ? wdata_q : (lane_hi ? {wbyte, 8'h00} : {8'h00, wbyte});
    assign ad_i_ext  = 16'(ad_i);
    assign rbyte     = lane_hi ? ad_i_ext[15:8] : ad_i_ext[7:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every
            // register samples pre-edge values regardless of block order.
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q    <= 1'b0;
            io_q    <= 1'b0;
            size_q  <= SIZE_BYTE;
            addr_q  <= '0;
            wdata_q <= '0;
            beats_q <= '0;
        end else if (start) begin
            we_q    <= we;
            io_q    <= io;
            size_q  <= size;
            addr_q  <= addr;
            wdata_q <= wdata;
            beats_q <= beat_count(BUS_BYTES, size, addr[0]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= '0;
        end else if (capture) begin
            if (full_word) begin
                rdata_q <= ad_i_ext;
            end else if (beat_idx == '0) begin
                rdata_q <= {8'h00, rbyte};
            end else begin
                rdata_q[15:8] <= rbyte;
            end
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // through the case statement can infer a latch.
        state_d = state_q;
        start   = 1'b0;
        advance = 1'b0;
        capture = 1'b0;
        ale     = 1'b0;
        rd_n    = 1'b1;
        wr_n    = 1'b1;
        den_n   = 1'b1;
        dtr     = 1'b1;
        iom     = 1'b0;
        ad_oe   = 1'b0;
        ad_o    = '0;
        hlda    = 1'b0;
        done    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (hold) begin
                    state_d = ST_HOLD;
                end else if (req) begin
                    state_d = ST_T1;
                    start   = 1'b1;
                end
            end
            ST_T1: begin
                ale     = 1'b1;
                ad_oe   = 1'b1;
                ad_o    = beat_addr[AD_W-1:0];
                dtr     = ~we_q;
                iom     = io_q;
                state_d = ST_T2;
            end
            ST_T2, ST_T3, ST_TW: begin
                dtr   = ~we_q;
                iom   = io_q;
                den_n = 1'b0;
                if (we_q) begin
                    wr_n  = 1'b0;
                    ad_oe = 1'b1;
                    ad_o  = wlanes[AD_W-1:0];
                end else begin
                    rd_n = 1'b0;
                end
                if (state_q == ST_T2) begin
                    state_d = ST_T3;
                end else if (ready) begin
                    state_d = ST_T4;
                    capture = ~we_q;
                end else begin
                    state_d = ST_TW;
                end
            end
            ST_T4: begin
                dtr = ~we_q;
                iom = io_q;
                // Hold is only granted between transfers, never between beats.
                if (!last_beat) begin
                    advance = 1'b1;
                    state_d = ST_T1;
                end else begin
                    done    = 1'b1;
                    state_d = hold ? ST_HOLD : ST_IDLE;
                end
            end
            ST_HOLD: begin
                hlda = 1'b1;
                if (!hold) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Reset holds busy low even while a request is already pending.
    assign busy  = rst && (((state_q != ST_IDLE) && (state_q != ST_HOLD)) || req);
    assign a     = beat_addr;
    assign rdata = rdata_q;

endmodule

// File: tb/tb_bus_cycle_unit.sv
// Directed bench for bus_cycle_unit: one byte-wide and one two-lane instance
// driven through hand-timed T-state sequences.
module tb_bus_cycle_unit;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    // Byte-wide instance
    logic        req8, we8, io8, size8, ready8, hold8;
    logic [19:0] addr8, a8;
    logic [15:0] wdata8, rdata8;
    logic [7:0]  ad_i8, ad_o8;
    logic        done8, busy8, ad_oe8, ale8, rd_n8, wr_n8, den_n8, dtr8, iom8, hlda8;

    // Two-lane instance
    logic        req16, we16, io16, size16, ready16, hold16;
    logic [19:0] addr16, a16;
    logic [15:0] wdata16, rdata16;
    logic [15:0] ad_i16, ad_o16;
    logic        done16, busy16, ad_oe16, ale16, rd_n16, wr_n16, den_n16, dtr16, iom16, hlda16;

    bus_cycle_unit #(.BUS_BYTES(1), .ADDR_W(20)) u_dut8 (
        .clk(clk), .rst(rst), .req(req8), .we(we8), .io(io8), .size(size8),
        .addr(addr8), .wdata(wdata8), .rdata(rdata8), .done(done8), .busy(busy8),
        .a(a8), .ad_o(ad_o8), .ad_i(ad_i8), .ad_oe(ad_oe8), .ale(ale8),
        .rd_n(rd_n8), .wr_n(wr_n8), .den_n(den_n8), .dtr(dtr8), .iom(iom8),
        .ready(ready8), .hold(hold8), .hlda(hlda8)
    );

    bus_cycle_unit #(.BUS_BYTES(2), .ADDR_W(20)) u_dut16 (
        .clk(clk), .rst(rst), .req(req16), .we(we16), .io(io16), .size(size16),
        .addr(addr16), .wdata(wdata16), .rdata(rdata16), .done(done16), .busy(busy16),
        .a(a16), .ad_o(ad_o16), .ad_i(ad_i16), .ad_oe(ad_oe16), .ale(ale16),
        .rd_n(rd_n16), .wr_n(wr_n16), .den_n(den_n16), .dtr(dtr16), .iom(iom16),
        .ready(ready16), .hold(hold16), .hlda(hlda16)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int seen;
        {req8, we8, io8, size8, hold8} = '0;
        ready8 = 1'b1; addr8 = '0; wdata8 = '0; ad_i8 = '0;
        {req16, we16, io16, size16, hold16} = '0;
        ready16 = 1'b1; addr16 = '0; wdata16 = '0; ad_i16 = '0;

        // Reset values
        step(); step();
        check("rst ale",   32'(ale8),   32'h0);
        check("rst rd_n",  32'(rd_n8),  32'h1);
        check("rst wr_n",  32'(wr_n8),  32'h1);
        check("rst den_n", 32'(den_n8), 32'h1);
        check("rst dtr",   32'(dtr8),   32'h1);
        check("rst ad_oe", 32'(ad_oe8), 32'h0);
        check("rst hlda",  32'(hlda8),  32'h0);
        check("rst done",  32'(done8),  32'h0);
        check("rst busy",  32'(busy8),  32'h0);
        check("rst rdata", 32'(rdata8), 32'h0);
        check("rst16 ad_oe", 32'(ad_oe16), 32'h0);
        rst = 1'b1;

        // Byte bus: word read at 0x0FFFF, two beats, address wraps into 0x10000
        step(); req8 = 1; we8 = 0; io8 = 0; size8 = 1; addr8 = 20'h0FFFF; ready8 = 1;
        #1 check("rd busy idle", 32'(busy8), 32'h1);
        step();  // T1 beat 0
        check("rd t1 ale",  32'(ale8),  32'h1);
        check("rd t1 a",    32'(a8),    32'h0FFFF);
        check("rd t1 ad_o", 32'(ad_o8), 32'hFF);
        check("rd t1 dtr",  32'(dtr8),  32'h1);
        req8 = 0;
        step();  // T2
        check("rd t2 rd_n",  32'(rd_n8),  32'h0);
        check("rd t2 ad_oe", 32'(ad_oe8), 32'h0);
        check("rd t2 den_n", 32'(den_n8), 32'h0);
        ad_i8 = 8'h34;
        step();  // T3
        step();  // T4
        check("rd t4 done", 32'(done8), 32'h0);
        check("rd t4 rd_n", 32'(rd_n8), 32'h1);
        step();  // T1 beat 1
        check("rd b1 ale",  32'(ale8),  32'h1);
        check("rd b1 a",    32'(a8),    32'h10000);
        check("rd b1 ad_o", 32'(ad_o8), 32'h00);
        step(); ad_i8 = 8'h12;  // T2
        step();  // T3
        step();  // T4, cycle 8
        check("rd done",  32'(done8),  32'h1);
        check("rd rdata", 32'(rdata8), 32'h1234);
        step();  // IDLE
        check("rd idle done",  32'(done8),  32'h0);
        check("rd idle busy",  32'(busy8),  32'h0);
        check("rd idle rdata", 32'(rdata8), 32'h1234);

        // Byte bus: I/O byte write with three wait states
        step(); req8 = 1; we8 = 1; io8 = 1; size8 = 0; addr8 = 20'h003F8; wdata8 = 16'h00A5; ready8 = 0;
        step();  // T1
        check("wr t1 iom",  32'(iom8),  32'h1);
        check("wr t1 dtr",  32'(dtr8),  32'h0);
        check("wr t1 ad_o", 32'(ad_o8), 32'hF8);
        req8 = 0;
        step();  // T2
        check("wr t2 wr_n",  32'(wr_n8),  32'h0);
        check("wr t2 ad_o",  32'(ad_o8),  32'hA5);
        check("wr t2 ad_oe", 32'(ad_oe8), 32'h1);
        step();  // T3
        step();  // TW1
        check("wr tw wr_n",  32'(wr_n8),  32'h0);
        check("wr tw den_n", 32'(den_n8), 32'h0);
        check("wr tw done",  32'(done8),  32'h0);
        step();  // TW2
        step();  // TW3
        check("wr tw3 ad_o", 32'(ad_o8), 32'hA5);
        ready8 = 1;
        step();  // T4, cycle 7
        check("wr done",    32'(done8),  32'h1);
        check("wr t4 wr_n", 32'(wr_n8),  32'h1);
        check("wr t4 oe",   32'(ad_oe8), 32'h0);
        check("wr t4 dtr",  32'(dtr8),   32'h0);
        step();

        // Byte bus: hold raised mid-transfer, plus a queued request
        step(); req8 = 1; we8 = 0; size8 = 1; addr8 = 20'h00200;
        step(); req8 = 0;  // T1
        step(); hold8 = 1; ad_i8 = 8'h78;  // T2
        step();  // T3
        step();  // T4 beat 0
        check("hd t4 hlda", 32'(hlda8), 32'h0);
        step();  // T1 beat 1
        check("hd b1 ale",  32'(ale8),  32'h1);
        check("hd b1 hlda", 32'(hlda8), 32'h0);
        check("hd b1 a",    32'(a8),    32'h00201);
        step(); ad_i8 = 8'h56;
        step();
        step();  // final T4
        check("hd done",  32'(done8),  32'h1);
        check("hd rdata", 32'(rdata8), 32'h5678);
        check("hd t4 hlda", 32'(hlda8), 32'h0);
        req8 = 1; size8 = 0; addr8 = 20'h00300;
        step();  // HOLD
        check("hd hlda",  32'(hlda8),  32'h1);
        check("hd busy",  32'(busy8),  32'h1);
        check("hd ale",   32'(ale8),   32'h0);
        check("hd ad_oe", 32'(ad_oe8), 32'h0);
        hold8 = 0;
        step();  // IDLE
        check("hd idle hlda", 32'(hlda8), 32'h0);
        check("hd idle ale",  32'(ale8),  32'h0);
        step();  // T1 of queued request
        check("hd q ale", 32'(ale8), 32'h1);
        check("hd q a",   32'(a8),   32'h00300);
        req8 = 0;
        step(); ad_i8 = 8'h9C;
        step();
        step();
        check("hd q done",  32'(done8),  32'h1);
        check("hd q rdata", 32'(rdata8), 32'h009C);
        step();

        // Byte bus: hold and req together in IDLE
        step(); hold8 = 1; req8 = 1; we8 = 0; size8 = 0; addr8 = 20'h00010;
        step();  // HOLD
        check("hr hlda", 32'(hlda8), 32'h1);
        check("hr ale",  32'(ale8),  32'h0);
        step();  // still HOLD
        check("hr ale2", 32'(ale8), 32'h0);
        hold8 = 0;
        step();  // IDLE
        check("hr idle hlda", 32'(hlda8), 32'h0);
        check("hr idle ale",  32'(ale8),  32'h0);
        step();  // T1
        check("hr t1 ale", 32'(ale8), 32'h1);
        check("hr t1 a",   32'(a8),   32'h00010);
        req8 = 0;
        step(); ad_i8 = 8'h42;
        step();
        step();
        check("hr done",  32'(done8),  32'h1);
        check("hr rdata", 32'(rdata8), 32'h0042);
        step();

        // Byte bus: reset during a wait state of a write
        step(); req8 = 1; we8 = 1; io8 = 0; size8 = 0; addr8 = 20'h00400; wdata8 = 16'h0033; ready8 = 0;
        step();  // T1
        step();  // T2
        step();  // T3
        step();  // TW
        check("rs tw wr_n", 32'(wr_n8), 32'h0);
        #2 rst = 1'b0;
        #1;
        check("rs wr_n",  32'(wr_n8),  32'h1);
        check("rs den_n", 32'(den_n8), 32'h1);
        check("rs ad_oe", 32'(ad_oe8), 32'h0);
        check("rs busy",  32'(busy8),  32'h0);
        check("rs rdata", 32'(rdata8), 32'h0);
        req8 = 0; ready8 = 1;
        step(); rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (done8 || ale8) seen++;
        end
        check("rs quiet", 32'(seen), 32'h0);

        // Two-lane bus: aligned word write, then unaligned word write
        step(); req16 = 1; we16 = 1; size16 = 1; addr16 = 20'h00100; wdata16 = 16'hBEEF; ready16 = 1;
        step();  // T1
        check("w16 t1 a",    32'(a16),    32'h00100);
        check("w16 t1 ad_o", 32'(ad_o16), 32'h0100);
        step();  // T2
        check("w16 t2 ad_o", 32'(ad_o16), 32'hBEEF);
        check("w16 t2 wr_n", 32'(wr_n16), 32'h0);
        step();  // T3
        step();  // T4
        check("w16 done", 32'(done16), 32'h1);
        addr16 = 20'h00101;
        step();  // IDLE with request still held
        check("w16 idle ale",  32'(ale16),  32'h0);
        check("w16 idle busy", 32'(busy16), 32'h1);
        step();  // T1 beat 0
        check("u16 t1 a", 32'(a16), 32'h00101);
        req16 = 0;
        step();
        check("u16 b0 ad_o", 32'(ad_o16), 32'hEF00);
        step();
        step();
        check("u16 b0 done", 32'(done16), 32'h0);
        step();  // T1 beat 1
        check("u16 b1 a", 32'(a16), 32'h00102);
        step();
        check("u16 b1 ad_o", 32'(ad_o16), 32'h00BE);
        step();
        step();
        check("u16 done", 32'(done16), 32'h1);
        step();

        // Two-lane bus: unaligned word read assembled from two lanes
        step(); req16 = 1; we16 = 0; size16 = 1; addr16 = 20'h00201;
        step(); req16 = 0;
        step(); ad_i16 = 16'h3400;
        check("r16 rd_n", 32'(rd_n16), 32'h0);
        step();
        step();
        step(); ad_i16 = 16'h0000;
        step(); ad_i16 = 16'h0012;
        step();
        step();
        check("r16 done",  32'(done16),  32'h1);
        check("r16 rdata", 32'(rdata16), 32'h1234);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_cycle_unit.md
# bus_cycle_unit

Parametrised bus interface unit that turns core-side transfer requests into multiplexed address/data bus cycles with T1–T4 timing, ready-driven wait states and hold/hlda bus arbitration. It supersedes the fixed 8-bit, no-wait control FSM. It sits between the CPU core's memory port (addr/data/we/io/block handshake) and the external multiplexed bus pins. It covers 8088-style (1-byte) and 8086-style (2-byte) buses through one parameter.

## Interface
- BUS_BYTES, 1, data lanes on the bus (legal values: 1 or 2)
- ADDR_W, 20, address width
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- req  in  1  transfer request; level, held until done
- we  in  1  1 = write, 0 = read
- io  in  1  1 = I/O space, 0 = memory
- size  in  1  0 = byte, 1 = word (16 bit)
- addr  in  ADDR_W  byte start address
- wdata  in  16  write data, little-endian
- rdata  out  16  assembled read data, valid when done=1
- done  out  1  one-cycle pulse: transfer complete
- busy  out  1  transfer in progress (core block signal)
- a  out  ADDR_W  address bus
- ad_o / ad_i  out / in  8*BUS_BYTES  multiplexed AD bus, output and input halves
- ad_oe  out  1  AD output enable
- ale, rd_n, wr_n, den_n, dtr, iom  out  1  bus strobes and status
- ready  in  1  slave ready; 0 inserts wait states
- hold  in  1  external bus request
- hlda  out  1  hold acknowledge

## Operation
- States: IDLE, T1, T2, T3, TW, T4, HOLD. Encoded in the shared package.
- IDLE
  - hold=1 → HOLD. Hold wins over a simultaneous req.
  - else req=1 → T1. Latch we, io, size, addr, wdata, and compute the beat count.
- Beats
  - BUS_BYTES=1: size+1 beats.
  - BUS_BYTES=2: 1 beat, except a word at odd addr, which takes 2 beats.
  - Beat n address = addr+n, wrapping modulo 2^ADDR_W.
  - For a 2-lane bus, the byte lane is selected by the beat address bit 0.
- T1
  - ale=1, ad_oe=1, ad_o = low bits of beat address, a = beat address, iom=io.
  - dtr = ~we, held through T4.
- T2
  - Read: rd_n=0, ad_oe=0.
  - Write: wr_n=0, ad_oe=1, ad_o = beat data.
  - den_n=0 from T2 through T3/TW.
- T3
  - ready=1 → T4 and, for a read, capture ad_i into the beat's byte(s) of rdata.
  - ready=0 → TW.
- TW: repeats while ready=0. It captures and moves to T4 on the first cycle with ready=1.
- T4
  - All strobes are inactive and ad_oe=0.
  - If beats remain: → T1 for the next beat. hold is not honoured between beats of one transfer.
  - Otherwise: done=1 for this cycle, then → HOLD if hold=1, else → IDLE.
- HOLD
  - hlda=1, all strobes inactive, ad_oe=0.
  - Returns to IDLE the cycle after hold is sampled 0.
  - A pending req then starts T1 on the following cycle.
- busy=1 in T1–T4 and TW, and in IDLE/HOLD while req is pending and not yet started.
- Request inputs are ignored once latched; a req drop mid-transfer does not abort it.
- Reset (at any time, including mid-cycle) forces the following values, then IDLE:
  - ale=0, rd_n=1, wr_n=1, den_n=1, dtr=1, ad_oe=0, hlda=0, done=0, busy=0, rdata=0, beat count=0.

## Timing
- Zero-wait byte transfer: req sampled in IDLE, T1–T4 follow, done in T4. That is 4 cycles from T1 to done.
- Each additional beat adds 4 cycles; each ready=0 sample adds 1 cycle (TW).
- rdata is registered and stable from the done cycle until the next transfer's first capture.
- hold latency: hlda rises at most 1 cycle after the current transfer's final T4. It rises 1 cycle after hold when idle.
- Next req can enter T1 the cycle after done (IDLE visited for one cycle).

## Structure
- Shared package (bcu_pkg) holds:
  - state localparams,
  - size encodings,
  - the BUS_BYTES legality check,
  - a beat-count function.
- One sub-module: bcu_beat_ctr. It is a clear/increment counter holding the beat index and producing last_beat.
- The FSM, address/data steering and rdata assembly stay in bus_cycle_unit.

## Test plan
- BUS_BYTES=1, read word at 0x0FFFF, ready=1, ad_i 0x34 then 0x12 → two beats; a=0x0FFFF then 0x10000; rdata=0x1234; done after 8 cycles.
- BUS_BYTES=1, write byte 0xA5 to I/O 0x003F8, ready low 3 cycles → iom=1; wr_n low T2–TW; 3 TW cycles; ad_o=0xA5 in data phase; done after 7 cycles.
- BUS_BYTES=2, word write 0xBEEF at 0x00100, then at 0x00101 → first is 1 beat; second is 2 beats with bytes 0xEF then 0xBE on lanes 1 and 0.
- hold asserted during beat 1 of a 2-beat read → no hlda between beats; hlda=1 the cycle after final T4; deassert hold → IDLE, and a queued req starts T1 two cycles later.
- hold and req both high in IDLE → HOLD first; transfer starts only after hold drops.
- rst pulled low during TW of a write → wr_n=1, den_n=1, ad_oe=0, busy=0 immediately; after release, IDLE and no done pulse.
